// File: rtl/trigger_counter.sv
// trigger_counter: key synchroniser + one-shot trigger FSM merged with a
// modulo-N up/down counter that steps on clock cycles or on trigger events.
module trigger_counter #(
    parameter int WIDTH       = 5,
    parameter int PULSE_LEN   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] modulus,
    input  logic             key,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             trig,
    output logic             busy
);

    // Pulse counter only needs to hold PULSE_LEN-1; keep at least one bit.
    localparam int PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_s;

    state_t                 state_q;
    logic [PCW-1:0]         pulse_cnt_q;
    logic                   trig_q;
    logic                   busy_q;

    logic [WIDTH-1:0]       count_q;
    logic [WIDTH-1:0]       count_d;
    logic                   tc_q;
    logic                   tc_d;

    logic [WIDTH-1:0]       top;
    logic                   start;
    logic                   step;

    // Shift the raw key through the synchroniser chain.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key};
        end
    end

    assign key_s = sync_q[SYNC_STAGES-1];

    // A press is recognised only from IDLE, so bounce in PULSE/HOLD is ignored.
    assign start = (state_q == ST_IDLE) && key_s;

    // Trigger FSM: one pulse of PULSE_LEN cycles per press, then wait for release.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pulse_cnt_q <= '0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_s) begin
                        state_q     <= ST_PULSE;
                        pulse_cnt_q <= PULSE_LOAD;
                        trig_q      <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt_q == '0) begin
                        trig_q <= 1'b0;
                        if (key_s) begin
                            state_q <= ST_HOLD;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - PCW'(1);
                    end
                end
                ST_HOLD: begin
                    if (!key_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    trig_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // modulus of zero selects the full 2^WIDTH range.
    assign top  = (modulus == '0) ? '1 : (modulus - WIDTH'(1));
    assign step = enable && (mode ? start : 1'b1);

    // Next count: load beats step; values above top are pulled back into range.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_value > top) ? top : load_value;
        end else if (step) begin
            if (!dir) begin
                if (count_q >= top) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = top;
                    tc_d    = 1'b1;
                end else if (count_q > top) begin
                    count_d = top;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Register count and the single-cycle terminal-count strobe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign trig  = trig_q;
    assign busy  = busy_q;

endmodule
